// File: rtl/piece_bag_gen_pkg.sv
// Shared types and helpers for the 7-bag tetromino generator.
// Piece encoding: I,J,L,O,S,T,Z = 0..6, with 3'b111 meaning "no piece".
package piece_bag_gen_pkg;

    typedef enum logic [2:0] {
        PIECE_I     = 3'd0,
        PIECE_J     = 3'd1,
        PIECE_L     = 3'd2,
        PIECE_O     = 3'd3,
        PIECE_S     = 3'd4,
        PIECE_T     = 3'd5,
        PIECE_Z     = 3'd6,
        PIECE_EMPTY = 3'd7
    } piece_e;

    typedef enum logic [1:0] {
        ST_FILL_CUR = 2'd0,
        ST_FILL_NXT = 2'd1,
        ST_READY    = 2'd2
    } state_e;

    localparam int         BAG_SIZE = 7;
    localparam logic [6:0] BAG_FULL = 7'h7F;

    function automatic logic [2:0] lowest_unused(input logic [6:0] mask);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = BAG_SIZE - 1; i >= 0; i--) begin
            if (!mask[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    function automatic logic [2:0] pieces_left(input logic [6:0] mask);
        logic [2:0] used;
        used = 3'd0;
        for (int i = 0; i < BAG_SIZE; i++) begin
            used = used + {2'b00, mask[i]};
        end
        return 3'(BAG_SIZE) - used;
    endfunction

endpackage

// File: rtl/piece_bag_gen_lfsr16.sv
// 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11, reloaded from seed on reset.
module piece_bag_gen_lfsr16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] seed,
    output logic [15:0] state
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    // Right-shifting Galois step: the bit shifted out folds back through the taps.
    always_comb begin
        state_d = state_q;
        if (en) begin
            state_d = {1'b0, state_q[15:1]} ^ (state_q[0] ? 16'hB400 : 16'h0000);
        end else begin
            state_d = state_q;
        end
    end

    // State register; async active-low reset reloads the seed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= seed;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/piece_bag_gen.sv
// 7-bag randomizer: holds the current spawn piece plus a one-deep preview and
// refills from an LFSR, falling back to the lowest unused piece after MAX_TRIES misses.
module piece_bag_gen
    import piece_bag_gen_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          MAX_TRIES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    output logic [2:0] piece_out,
    output logic [2:0] next_out,
    output logic       ready,
    output logic [2:0] bag_remaining
);

    // An all-zero seed would lock the LFSR, so it is substituted.
    localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    logic [15:0] lfsr_s;
    logic        lfsr_unused_s;
    logic [2:0]  cand_s;
    logic [7:0]  mask_ext_s;
    logic        commit_s;
    logic [2:0]  pick_s;
    logic [6:0]  mask_set_s;
    logic [6:0]  mask_next_s;

    state_e      state_q;
    logic [2:0]  piece_q;
    logic [2:0]  next_q;
    logic        ready_q;
    logic        pending_q;
    logic [6:0]  mask_q;
    logic [7:0]  tries_q;

    piece_bag_gen_lfsr16 u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en    (1'b1),
        .seed  (SEED_EFF),
        .state (lfsr_s)
    );

    assign cand_s        = lfsr_s[2:0];
    assign lfsr_unused_s = ^lfsr_s[15:3];
    // Index 7 reads as "already used" so a 3'b111 candidate is simply a miss.
    assign mask_ext_s    = {1'b1, mask_q};

    // One fill attempt per cycle: forced fallback once the try budget is spent.
    always_comb begin
        commit_s = 1'b0;
        pick_s   = 3'd0;
        if (tries_q == 8'(MAX_TRIES)) begin
            commit_s = 1'b1;
            pick_s   = lowest_unused(mask_q);
        end else if (!mask_ext_s[cand_s]) begin
            commit_s = 1'b1;
            pick_s   = cand_s;
        end else begin
            commit_s = 1'b0;
            pick_s   = 3'd0;
        end
    end

    assign mask_set_s  = mask_q | (7'b0000001 << pick_s);
    assign mask_next_s = (mask_set_s == BAG_FULL) ? 7'h00 : mask_set_s;

    // Fill / ready FSM; a req seen while not ready is remembered once in pending_q.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_FILL_CUR;
            piece_q   <= PIECE_EMPTY;
            next_q    <= PIECE_EMPTY;
            ready_q   <= 1'b0;
            pending_q <= 1'b0;
            mask_q    <= 7'h00;
            tries_q   <= 8'd0;
        end else begin
            case (state_q)
                ST_FILL_CUR: begin
                    if (req) pending_q <= 1'b1;
                    if (commit_s) begin
                        piece_q <= pick_s;
                        mask_q  <= mask_next_s;
                        tries_q <= 8'd0;
                        state_q <= ST_FILL_NXT;
                    end else begin
                        tries_q <= tries_q + 8'd1;
                    end
                end
                ST_FILL_NXT: begin
                    if (req) pending_q <= 1'b1;
                    if (commit_s) begin
                        next_q  <= pick_s;
                        mask_q  <= mask_next_s;
                        tries_q <= 8'd0;
                        ready_q <= 1'b1;
                        state_q <= ST_READY;
                    end else begin
                        tries_q <= tries_q + 8'd1;
                    end
                end
                ST_READY: begin
                    if (req || pending_q) begin
                        piece_q   <= next_q;
                        next_q    <= PIECE_EMPTY;
                        ready_q   <= 1'b0;
                        pending_q <= 1'b0;
                        state_q   <= ST_FILL_NXT;
                    end
                end
                default: begin
                    state_q <= ST_FILL_CUR;
                end
            endcase
        end
    end

    assign piece_out     = piece_q;
    assign next_out      = next_q;
    assign ready         = ready_q;
    assign bag_remaining = pieces_left(mask_q);

endmodule
